// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one signed x unsigned multiplier among NUM_REQ lanes,
// with a 2-stage backpressured pipeline. Define MUL_ARB_STATS_EN to add the stall_cnt output.
module mul_share_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2,
    parameter int A_WIDTH  = 16,
    parameter int B_WIDTH  = 11,
    parameter int P_WIDTH  = 26
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [P_WIDTH-1:0]         res_data,
    output logic [ID_WIDTH-1:0]        res_id
`ifdef MUL_ARB_STATS_EN
    ,
    output logic [15:0]                stall_cnt
`endif
);

    logic [ID_WIDTH-1:0] ptr_r;
    logic                s1_valid_r;
    logic [A_WIDTH-1:0]  s1_a_r;
    logic [B_WIDTH-1:0]  s1_b_r;
    logic [ID_WIDTH-1:0] s1_id_r;
    logic                s2_valid_r;
    logic [P_WIDTH-1:0]  s2_data_r;
    logic [ID_WIDTH-1:0] s2_id_r;

    logic                adv1_s;
    logic                adv2_s;
    logic                take_s;
    logic                grant_found_s;
    logic [ID_WIDTH-1:0] grant_id_s;
    logic [ID_WIDTH:0]   cand_s;
    logic [P_WIDTH-1:0]  a_ext_s;
    logic [P_WIDTH-1:0]  b_ext_s;
    logic [P_WIDTH-1:0]  prod_s;

    logic [A_WIDTH-1:0]  lane_a_s [NUM_REQ];
    logic [B_WIDTH-1:0]  lane_b_s [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lane_a_s[i] = req_a[i*A_WIDTH +: A_WIDTH];
        assign lane_b_s[i] = req_b[i*B_WIDTH +: B_WIDTH];
    end

    assign adv2_s = ~s2_valid_r | res_ready;
    assign adv1_s = ~s1_valid_r | adv2_s;
    assign take_s = grant_found_s & adv1_s & ~ap_rst;

    // Round-robin scan: first valid lane at or above the pointer, wrapping past NUM_REQ-1.
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = {ID_WIDTH{1'b0}};
        cand_s        = {(ID_WIDTH+1){1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = {1'b0, ptr_r} + (ID_WIDTH+1)'(k);
            cand_s = (cand_s >= (ID_WIDTH+1)'(NUM_REQ)) ? cand_s - (ID_WIDTH+1)'(NUM_REQ) : cand_s;
            if (!grant_found_s && req_valid[cand_s[ID_WIDTH-1:0]]) begin
                grant_found_s = 1'b1;
                grant_id_s    = cand_s[ID_WIDTH-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Ready is presented only to the granted lane, and only while S1 can accept.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if (take_s) begin
            req_ready[grant_id_s] = 1'b1;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Sign-extend a, zero-extend b; the low P_WIDTH bits of the product are the same at any wider width.
    assign a_ext_s = {{(P_WIDTH-A_WIDTH){s1_a_r[A_WIDTH-1]}}, s1_a_r};
    assign b_ext_s = {{(P_WIDTH-B_WIDTH){1'b0}}, s1_b_r};
    assign prod_s  = a_ext_s * b_ext_s;

    // Pointer and both pipeline stages.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            ptr_r      <= {ID_WIDTH{1'b0}};
            s1_valid_r <= 1'b0;
            s1_a_r     <= {A_WIDTH{1'b0}};
            s1_b_r     <= {B_WIDTH{1'b0}};
            s1_id_r    <= {ID_WIDTH{1'b0}};
            s2_valid_r <= 1'b0;
            s2_data_r  <= {P_WIDTH{1'b0}};
            s2_id_r    <= {ID_WIDTH{1'b0}};
        end else begin
            if (take_s) begin
                ptr_r <= (grant_id_s == ID_WIDTH'(NUM_REQ-1)) ? {ID_WIDTH{1'b0}}
                                                               : grant_id_s + ID_WIDTH'(1'b1);
            end else begin
                ptr_r <= ptr_r;
            end
            if (adv1_s) begin
                s1_valid_r <= take_s;
                if (take_s) begin
                    s1_a_r  <= lane_a_s[grant_id_s];
                    s1_b_r  <= lane_b_s[grant_id_s];
                    s1_id_r <= grant_id_s;
                end else begin
                    s1_id_r <= s1_id_r;
                end
            end else begin
                s1_valid_r <= s1_valid_r;
            end
            if (adv2_s) begin
                s2_valid_r <= s1_valid_r;
                if (s1_valid_r) begin
                    s2_data_r <= prod_s;
                    s2_id_r   <= s1_id_r;
                end else begin
                    s2_id_r <= s2_id_r;
                end
            end else begin
                s2_valid_r <= s2_valid_r;
            end
        end
    end

    assign res_valid = s2_valid_r;
    assign res_data  = s2_data_r;
    assign res_id    = s2_id_r;

`ifdef MUL_ARB_STATS_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of cycles where a result is presented but not taken.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            stall_cnt_r <= 16'h0000;
        end else if (s2_valid_r && !res_ready && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one 16-bit-signed × 11-bit-unsigned multiplier between NUM_REQ requesters in the generated network datapath.
- Requesters are typically unrolled dense-layer lanes.
- Grants are round-robin, one multiply is issued per cycle, and results return tagged with the requester index.
- A fixed 2-stage pipeline handles backpressure from the single result consumer.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_WIDTH, 2, width of the requester tag; must be ≥ ceil(log2(NUM_REQ)).
- A_WIDTH, 16, signed operand width.
- B_WIDTH, 11, unsigned operand width.
- P_WIDTH, 26, result width.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*A_WIDTH  signed operands; lane i is bits [i*A_WIDTH +: A_WIDTH].
- req_b  in  NUM_REQ*B_WIDTH  unsigned operands; same packing as req_a.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accept.
- res_data  out  P_WIDTH  product.
- res_id  out  ID_WIDTH  index of the requester that issued the product.

Behaviour:
- Reset (ap_rst=1 at a clock edge):
  - Both pipeline stages are cleared to invalid.
  - res_valid=0, res_data=0, res_id=0.
  - Round-robin pointer = 0.
  - req_ready=0 during the reset cycle.
- Reset asserted mid-operation discards all in-flight operations; nothing is replayed.
- Pipeline:
  - S1 holds the registered operands and id.
  - S2 holds the registered product and id, and drives res_*.
- Stall and advance rules:
  - adv2 = !s2_valid | res_ready.
  - adv1 = !s1_valid | adv2.
  - S1 moves into S2 only when adv2.
- Issue:
  - When adv1 and some req_valid is set, grant the first requester with valid, scanning from the pointer upward with wrap-around from NUM_REQ-1 to 0.
  - req_ready[g] is combinational: asserted only for the granted lane, and only when adv1.
  - The transfer occurs on the cycle where req_valid[g] & req_ready[g].
  - After a transfer, pointer = g+1, wrapping to 0 after NUM_REQ-1.
  - With no grant, the pointer holds.
- A requester must hold req_valid and its operands stable until accepted. The arbiter never revokes a grant while that grant is being presented.
- Latency: an operand accepted at edge t appears with res_valid=1 after edge t+1, when res_ready is continuously high.
- Throughput: 1 result per cycle sustained.
- Backpressure:
  - With res_valid=1 and res_ready=0, S2 holds.
  - S1 fills once, then req_ready is all zero until the stall clears.
  - res_data and res_id stay stable while stalled.
- Simultaneous events: when S2 drains, S1 advances and a new grant is accepted, all in the same cycle, there are no bubbles.
- Arithmetic:
  - Full product = signed(a) × signed({1'b0,b}).
  - res_data = low P_WIDTH bits of the full product; it wraps and does not saturate.
  - The multiply is combinational between S1 and S2.
- Fairness: under continuous requests from all lanes, each lane is granted exactly once per NUM_REQ accepted transfers.
- An id ≥ NUM_REQ is never produced.

Optional Feature:
- MUL_ARB_STATS_EN defined:
  - Adds output port stall_cnt, 16 bits.
  - It counts cycles with res_valid & !res_ready and saturates at 16'hFFFF.
  - It is cleared by ap_rst and updated with 1-cycle latency.
- Undefined:
  - The port and the counter are absent.
  - All other behaviour is identical.

Test Plan:
- Single lane: lane 2 issues a=1234, b=1000 with res_ready=1 → res_valid one cycle after accept, res_data=1234000, res_id=2.
- Wrap boundary: a=-32768, b=2047 → full product -67076096; res_data=26'h0008000 (32768). Also a=-1, b=1 → res_data=26'h3FFFFFF.
- All 4 lanes valid for 8 transfers, starting from pointer 0 → grant order 0,1,2,3,0,1,2,3; res_id sequence matches, with no idle cycles.
- res_ready=0 for 5 cycles with all lanes requesting:
  - S2 and S1 hold; req_ready=0 after S1 fills.
  - Outputs stay stable.
  - On release, results follow in order with no loss or duplication.
  - With MUL_ARB_STATS_EN, stall_cnt=5.
- ap_rst pulsed while both stages are valid → next cycle res_valid=0 and pointer=0; the first post-reset request from lane 3 gets res_id=3.
- Sparse requests from lanes 1 and 3 only, pointer starting at 2 → grants go 3, then 1, then 3.
